// File: rtl/btn_press_pkg.sv
// rtl/btn_press_pkg.sv - shared FSM state type and default timing constants for btn_press_ctrl
package btn_press_pkg;

  typedef enum logic [1:0] {
    WAIT_REL = 2'd0,
    IDLE     = 2'd1,
    SHORT    = 2'd2,
    HOLD     = 2'd3
  } btn_state_e;

  localparam int unsigned PIX_CLK_HZ       = 27_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYC = PIX_CLK_HZ / 100;  // 10 ms
  localparam int unsigned DEF_HOLD_CYC     = PIX_CLK_HZ;        // 1 s
  localparam int unsigned DEF_REPEAT_CYC   = PIX_CLK_HZ / 10;   // 100 ms
  localparam int          DEF_CNT_W        = 25;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchronizer plus stable-count debounce for the active-low button pin
module btn_debounce
  import btn_press_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int          CNT_W        = DEF_CNT_W
) (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic btn_n_i,
  output logic pressed_o,
  output logic pressed_nx_o
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             sync1_q, sync2_q;
  logic             raw_pressed;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Two-flop synchronizer; resets to the released (high) pin level.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
    end
  end

  assign raw_pressed = ~sync2_q;

  // Count consecutive disagreeing cycles; accept the new level after DEBOUNCE_CYC of them.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (raw_pressed != level_q) begin
      if (cnt_q == DB_LAST) begin
        level_d = raw_pressed;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // Debounced level and its stability counter.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pressed_o    = level_q;
  // Next-cycle level lets the classifier switch state on the same edge that pressed changes.
  assign pressed_nx_o = level_d;

endmodule

// File: rtl/btn_press_ctrl.sv
// rtl/btn_press_ctrl.sv - debounced button classifier (short/hold/auto-repeat); repeat pulses built only with BTN_PRESS_REPEAT_EN
module btn_press_ctrl
  import btn_press_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC,
  parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC,
  parameter int          CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_n,
  output logic pressed,
  output logic short_pulse,
  output logic hold_start,
  output logic repeat_pulse,
  output logic inc_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  // A button held through reset shows pressed within DEBOUNCE_CYC+2 cycles, so the
  // classifier only arms after the level has read released for longer than that.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(DEBOUNCE_CYC + 1);
  localparam longint unsigned  CNT_SPAN  = 64'd1 << CNT_W;

  // Elaborates only for a CNT_W too narrow to reach every terminal count.
  if (CNT_SPAN <= 64'(HOLD_CYC) || CNT_SPAN <= 64'(REPEAT_CYC) ||
      CNT_SPAN <= 64'(DEBOUNCE_CYC)) begin : g_cnt_w_too_narrow
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             pressed_nx;
  logic             short_q, short_d;
  logic             hold_q, hold_d;
  logic             inc_q, inc_d;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .CNT_W       (CNT_W)
  ) u_debounce (
    .clk_i       (clk),
    .resetn_i    (resetn),
    .btn_n_i     (btn_n),
    .pressed_o   (pressed),
    .pressed_nx_o(pressed_nx)
  );

`ifdef BTN_PRESS_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_q, rep_d;
`endif

  // Classify the press; hold_cnt doubles as the released-time counter in WAIT_REL.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    short_d    = 1'b0;
    hold_d     = 1'b0;
`ifdef BTN_PRESS_REPEAT_EN
    rep_cnt_d  = rep_cnt_q;
    rep_d      = 1'b0;
`endif
    case (state_q)
      WAIT_REL: begin
        if (pressed_nx) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == WAIT_LAST) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = sat_inc(hold_cnt_q);
        end
      end
      IDLE: begin
        if (pressed_nx) begin
          state_d    = SHORT;
          hold_cnt_d = '0;
        end
      end
      SHORT: begin
        // Threshold is tested first so a release on the same cycle still yields a hold.
        if (hold_cnt_q == HOLD_LAST) begin
          hold_d  = 1'b1;
          state_d = HOLD;
`ifdef BTN_PRESS_REPEAT_EN
          rep_cnt_d = '0;
`endif
        end else if (!pressed_nx) begin
          short_d = 1'b1;
          state_d = IDLE;
        end else begin
          hold_cnt_d = sat_inc(hold_cnt_q);
        end
      end
      HOLD: begin
        if (!pressed_nx) begin
          state_d = IDLE;
        end
`ifdef BTN_PRESS_REPEAT_EN
        else if (rep_cnt_q == REP_LAST) begin
          rep_d     = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = sat_inc(rep_cnt_q);
        end
`endif
      end
      default: state_d = WAIT_REL;
    endcase
`ifdef BTN_PRESS_REPEAT_EN
    inc_d = short_d | hold_d | rep_d;
`else
    inc_d = short_d | hold_d;
`endif
  end

  // FSM state, counters and registered event pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= WAIT_REL;
      hold_cnt_q <= '0;
      short_q    <= 1'b0;
      hold_q     <= 1'b0;
      inc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      short_q    <= short_d;
      hold_q     <= hold_d;
      inc_q      <= inc_d;
    end
  end

`ifdef BTN_PRESS_REPEAT_EN
  // Repeat counter and pulse exist only when auto-repeat is built in.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rep_cnt_q <= '0;
      rep_q     <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_q     <= rep_d;
    end
  end
  assign repeat_pulse = rep_q;
`else
  assign repeat_pulse = 1'b0;
`endif

  assign short_pulse = short_q;
  assign hold_start  = hold_q;
  assign inc_pulse   = inc_q;

endmodule

// File: tb/tb_btn_press_ctrl.sv
// tb/tb_btn_press_ctrl.sv - randomized and directed bench for btn_press_ctrl against a timeline model
module tb_btn_press_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 5;
`ifdef BTN_PRESS_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic btn_n = 1'b1;
  logic pressed, short_pulse, hold_start, repeat_pulse, inc_pulse;

  btn_press_ctrl #(
    .DEBOUNCE_CYC(DEB),
    .HOLD_CYC    (HOLD),
    .REPEAT_CYC  (REP),
    .CNT_W       (25)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .btn_n       (btn_n),
    .pressed     (pressed),
    .short_pulse (short_pulse),
    .hold_start  (hold_start),
    .repeat_pulse(repeat_pulse),
    .inc_pulse   (inc_pulse)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: pin history, debounced timeline, and a press timeline measured in cycles since pressed rose.
  logic m_s1, m_s2, m_pressed;
  int   m_diff_run, m_low_run, m_age, m_mode;  // mode 0 waiting for release, 1 idle, 2 press in progress
  logic e_short, e_hold, e_rep, e_inc;

  int   n_short, n_hold, n_rep, n_inc, n_rise;
  int   rise_cyc, hold_cyc, rep_cyc;
  logic last_p;

  task automatic model_reset();
    m_s1 = 1'b1; m_s2 = 1'b1; m_pressed = 1'b0;
    m_diff_run = 0; m_low_run = 0; m_age = 0; m_mode = 0;
    e_short = 1'b0; e_hold = 1'b0; e_rep = 1'b0; e_inc = 1'b0;
  endtask

  task automatic model_edge(input logic b);
    logic raw, pn;
    raw = !m_s2;
    if (raw != m_pressed) begin
      m_diff_run++;
      if (m_diff_run == DEB) begin
        m_pressed  = raw;
        m_diff_run = 0;
      end
    end else begin
      m_diff_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = b;
    pn = m_pressed;
    e_short = 1'b0; e_hold = 1'b0; e_rep = 1'b0;
    if (m_mode == 0) begin
      m_low_run = pn ? 0 : m_low_run + 1;
      if (!pn && m_low_run >= DEB + 2) m_mode = 1;
    end else if (m_mode == 1) begin
      if (pn) begin m_mode = 2; m_age = 0; end
    end else begin
      m_age++;
      if (m_age == HOLD) e_hold = 1'b1;
      else if (m_age < HOLD) begin
        if (!pn) begin e_short = 1'b1; m_mode = 1; end
      end else if (!pn) m_mode = 1;
      else if (REP_EN && ((m_age - HOLD) % REP == 0)) e_rep = 1'b1;
    end
    e_inc = e_short | e_hold | e_rep;
  endtask

  task automatic check_outputs();
    logic [4:0] got, exp;
    got = {pressed, short_pulse, hold_start, repeat_pulse, inc_pulse};
    exp = {m_pressed, e_short, e_hold, e_rep, e_inc};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL outputs cycle %0d: got pressed/short/hold/rep/inc=%b required %b", cyc, got, exp);
    end
    if (pressed && !last_p) begin n_rise++; rise_cyc = cyc; end
    last_p = pressed;
    if (short_pulse) n_short++;
    if (hold_start) begin n_hold++; hold_cyc = cyc; end
    if (repeat_pulse) begin n_rep++; if (rep_cyc < 0) rep_cyc = cyc; end
    if (inc_pulse) n_inc++;
  endtask

  task automatic lit(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic clear_tallies();
    n_short = 0; n_hold = 0; n_rep = 0; n_inc = 0; n_rise = 0;
    rise_cyc = -1; hold_cyc = -1; rep_cyc = -1;
  endtask

  task automatic step(input logic b);
    btn_n = b;
    model_edge(b);
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic level(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  int press_at;

  initial begin
    last_p = 1'b0;
    clear_tallies();
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    resetn = 1'b1;
    level(1'b1, 20);

    // Short press of 10 cycles.
    clear_tallies();
    press_at = cyc + 1;
    level(1'b0, 10);
    level(1'b1, 20);
    lit("t1_press_latency", rise_cyc - press_at + 1, DEB + 2);
    lit("t1_short", n_short, 1);
    lit("t1_inc", n_inc, 1);
    lit("t1_hold", n_hold, 0);

    // 3-cycle glitch.
    clear_tallies();
    level(1'b0, 3);
    level(1'b1, 20);
    lit("t2_rise", n_rise, 0);
    lit("t2_inc", n_inc, 0);

    // 40-cycle hold.
    clear_tallies();
    level(1'b0, 40);
    level(1'b1, 20);
    lit("t3_hold", n_hold, 1);
    lit("t3_hold_delay", hold_cyc - rise_cyc, HOLD);
    lit("t3_short", n_short, 0);
    lit("t3_rep", n_rep, REP_EN ? 3 : 0);
    lit("t3_inc", n_inc, REP_EN ? 4 : 1);
    if (REP_EN) lit("t3_first_rep", rep_cyc - hold_cyc, REP);

    // Release landing on the last SHORT cycle, and one cycle earlier.
    clear_tallies();
    level(1'b0, HOLD);
    level(1'b1, 20);
    lit("t4_hold", n_hold, 1);
    lit("t4_short", n_short, 0);
    clear_tallies();
    level(1'b0, HOLD - 1);
    level(1'b1, 20);
    lit("t4b_short", n_short, 1);
    lit("t4b_hold", n_hold, 0);

    // Reset asserted mid-press with the button held across it.
    clear_tallies();
    level(1'b0, 10);
    #2 resetn = 1'b0;
    #1;
    lit("t5_async_out", {pressed, short_pulse, hold_start, repeat_pulse, inc_pulse}, 0);
    model_reset();
    last_p = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    clear_tallies();
    level(1'b0, 30);
    lit("t5_held_events", n_inc, 0);
    level(1'b1, 20);
    level(1'b0, 8);
    level(1'b1, 20);
    lit("t5_short", n_short, 1);
    lit("t5_inc", n_inc, 1);

    // Random press patterns across glitch, short, boundary and hold lengths.
    for (int i = 0; i < 80; i++) begin
      int kind, len;
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: len = int'($urandom_range(1, 3));
        1: len = int'($urandom_range(4, 14));
        2: len = int'($urandom_range(HOLD - 2, HOLD + 2));
        default: len = int'($urandom_range(HOLD + 3, HOLD + 35));
      endcase
      level(1'b0, len);
      level(1'b1, int'($urandom_range(1, 16)));
    end
    level(1'b1, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
